// File: rtl/fwd_pkg.sv
// Shared types and default sizing for the forwarding / hazard scoreboard.
// Forward-select encoding: 0 = regfile, 1..NUM_FWD = stage k-1, NUM_FWD+1 = multi-cycle writeback.
package fwd_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int NUM_FWD_DEF  = 2;
  localparam int SEL_W_DEF    = $clog2(NUM_FWD_DEF + 2);
  localparam int CNT_W_DEF    = 16;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;

  typedef enum logic [SEL_W_DEF-1:0] {
    FWD_RF = '0,
    FWD_MC = SEL_W_DEF'(NUM_FWD_DEF + 1)
  } fwd_sel_e;

endpackage

// File: rtl/fwd_operand_sel.sv
// Per-operand bypass selection: youngest matching stage wins, then MC writeback, else regfile.
// Also reports whether the winning stage's result is not yet ready.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic [NUM_FWD*REG_AW-1:0] stg_rd,
  input  logic [NUM_FWD-1:0]        stg_regwrite,
  input  logic [NUM_FWD-1:0]        stg_ready,
  input  logic                      mc_wb_valid,
  input  logic [REG_AW-1:0]         mc_wb_rd,
  output logic [SEL_W-1:0]          sel,
  output logic                      not_ready
);

  logic rs_nz;
  assign rs_nz = (rs != '0);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    sel       = (mc_wb_valid && (mc_wb_rd == rs) && rs_nz) ? SEL_W'(NUM_FWD + 1) : SEL_W'(FWD_RF);
    not_ready = 1'b0;
    // Walk oldest to youngest so a younger match overwrites an older one.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (stg_regwrite[k] && (stg_rd[k*REG_AW +: REG_AW] == rs) && rs_nz) begin
        sel       = SEL_W'(k + 1);
        not_ready = ~stg_ready[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding, load-use / multi-cycle hazard detection and busy scoreboard
// sitting beside the ID/EX boundary; also counts stall cycles (saturating).
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_FWD  = NUM_FWD_DEF,
  parameter int SEL_W    = $clog2(NUM_FWD + 2),
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_AW-1:0]         id_rs1,
  input  logic [REG_AW-1:0]         id_rs2,
  input  logic                      id_valid,
  input  logic [NUM_FWD*REG_AW-1:0] stg_rd,
  input  logic [NUM_FWD-1:0]        stg_regwrite,
  input  logic [NUM_FWD-1:0]        stg_ready,
  input  logic                      mc_issue,
  input  logic [REG_AW-1:0]         mc_rd,
  input  logic                      mc_wb_valid,
  input  logic [REG_AW-1:0]         mc_wb_rd,
  input  logic                      mc_kill,
  output logic [SEL_W-1:0]          fwd_a,
  output logic [SEL_W-1:0]          fwd_b,
  output logic                      stall,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                nr_a, nr_b;
  logic                stall_data, stall_sb, waw;

  fwd_operand_sel #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_sel_a (
    .rs(id_rs1), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite), .stg_ready(stg_ready),
    .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd), .sel(fwd_a), .not_ready(nr_a)
  );

  fwd_operand_sel #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_sel_b (
    .rs(id_rs2), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite), .stg_ready(stg_ready),
    .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd), .sel(fwd_b), .not_ready(nr_b)
  );

  // A same-cycle writeback releases the busy register for its reader.
  assign stall_data = nr_a | nr_b;
  assign stall_sb   = (busy_q[id_rs1] && !(mc_wb_valid && (mc_wb_rd == id_rs1)))
                    | (busy_q[id_rs2] && !(mc_wb_valid && (mc_wb_rd == id_rs2)));
  assign waw        = mc_issue && (mc_rd != '0) && busy_q[mc_rd];
  assign stall      = id_valid && (stall_data || stall_sb || waw);

  // Writeback clears first so a same-rd issue leaves the new op outstanding; kill beats both.
  always_comb begin
    busy_d = busy_q;
    if (mc_wb_valid)                busy_d[mc_wb_rd] = 1'b0;
    if (mc_issue && (mc_rd != '0))  busy_d[mc_rd]    = 1'b1;
    if (mc_kill)                    busy_d           = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_vec  = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed self-checking bench for fwd_hazard_scoreboard with hand-computed expectations.
module tb_fwd_hazard_scoreboard;
  import fwd_pkg::*;

  logic        clk;
  logic        rst_n;
  reg_addr_t   id_rs1, id_rs2, mc_rd, mc_wb_rd;
  logic        id_valid, mc_issue, mc_wb_valid, mc_kill;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_regwrite, stg_ready;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fwd_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_valid(id_valid),
    .stg_rd(stg_rd), .stg_regwrite(stg_regwrite), .stg_ready(stg_ready),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
    .mc_kill(mc_kill), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    stg_regwrite = 2'b11;
    stg_rd       = {5'd3, 5'd3};
    stg_ready    = 2'b11;
    id_rs1       = 5'd3;
    id_rs2       = 5'd0;
    id_valid     = 1'b0;
    mc_issue     = 1'b0;
    mc_rd        = 5'd0;
    mc_wb_valid  = 1'b0;
    mc_wb_rd     = 5'd0;
    mc_kill      = 1'b0;
    #2;
    check("rst_busy_in", busy_vec, 32'h0);
    check("rst_cnt_in", stall_cnt, 16'h0);
    #10 rst_n = 1'b1;
    #1;
    check("rst_fwd_a", fwd_a, 2'd1);
    check("rst_fwd_b", fwd_b, 2'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_busy", busy_vec, 32'h0);
    check("rst_cnt", stall_cnt, 16'h0);

    // Priority: both stages write x7, youngest wins; then only stage 1.
    step();
    stg_rd = {5'd7, 5'd7}; id_rs1 = 5'd7; id_rs2 = 5'd7; id_valid = 1'b1;
    #1;
    check("prio_a", fwd_a, 2'd1);
    check("prio_b", fwd_b, 2'd1);
    check("prio_stall", stall, 1'b0);
    stg_regwrite = 2'b10;
    #1;
    check("prio_old_a", fwd_a, 2'd2);
    check("prio_old_b", fwd_b, 2'd2);

    // Load-use on rs2 from stage 0.
    step();
    stg_rd = {5'd0, 5'd9}; stg_regwrite = 2'b01; stg_ready = 2'b10;
    id_rs1 = 5'd0; id_rs2 = 5'd9;
    #1;
    check("lu_stall", stall, 1'b1);
    check("lu_fwd_b", fwd_b, 2'd1);
    check("lu_cnt0", stall_cnt, 16'd0);
    step();
    check("lu_cnt1", stall_cnt, 16'd1);
    stg_ready = 2'b11;
    #1;
    check("lu_ready_stall", stall, 1'b0);
    check("lu_ready_fwd_b", fwd_b, 2'd1);
    // Younger not-ready match stalls even though the older stage is ready.
    stg_rd = {5'd9, 5'd9}; stg_regwrite = 2'b11; stg_ready = 2'b10;
    #1;
    check("lu_young_stall", stall, 1'b1);
    check("lu_young_fwd_b", fwd_b, 2'd1);
    step();
    check("lu_cnt2", stall_cnt, 16'd2);
    stg_regwrite = 2'b00; stg_ready = 2'b11; id_rs2 = 5'd0;

    // Multi-cycle hazard on x5.
    id_valid = 1'b0; id_rs1 = 5'd5; mc_issue = 1'b1; mc_rd = 5'd5;
    step();
    mc_issue = 1'b0;
    check("mc_busy5", busy_vec, 32'h0000_0020);
    id_valid = 1'b1;
    #1;
    check("mc_stall", stall, 1'b1);
    check("mc_fwd_a_rf", fwd_a, FWD_RF);
    step(); step(); step();
    check("mc_stall3", stall, 1'b1);
    check("mc_cnt5", stall_cnt, 16'd5);
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd5;
    #1;
    check("mc_wb_stall", stall, 1'b0);
    check("mc_wb_fwd_a", fwd_a, FWD_MC);
    step();
    mc_wb_valid = 1'b0;
    check("mc_wb_busy", busy_vec, 32'h0);
    check("mc_wb_cnt", stall_cnt, 16'd5);

    // Simultaneous issue/writeback to x12, WAW, then kill.
    id_valid = 1'b0; id_rs1 = 5'd0; mc_issue = 1'b1; mc_rd = 5'd12;
    step();
    check("sim_busy12", busy_vec, 32'h0000_1000);
    id_valid = 1'b1;
    #1;
    check("waw_stall", stall, 1'b1);
    id_valid = 1'b0;
    #1;
    check("waw_novalid", stall, 1'b0);
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd12;
    step();
    check("sim_wb_issue", busy_vec, 32'h0000_1000);
    mc_wb_valid = 1'b0; mc_kill = 1'b1; mc_rd = 5'd4;
    step();
    mc_kill = 1'b0; mc_issue = 1'b0;
    check("kill_busy", busy_vec, 32'h0);

    // Writeback to a non-busy register.
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd20; id_rs1 = 5'd20;
    #1;
    check("wb_nb_fwd_a", fwd_a, FWD_MC);
    step();
    mc_wb_valid = 1'b0;
    check("wb_nb_busy", busy_vec, 32'h0);

    // x0 boundaries.
    id_valid = 1'b1; id_rs1 = 5'd0; stg_rd = {5'd0, 5'd0}; stg_regwrite = 2'b01; stg_ready = 2'b00;
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd0;
    #1;
    check("x0_fwd_a", fwd_a, 2'd0);
    check("x0_stall", stall, 1'b0);
    mc_wb_valid = 1'b0; stg_regwrite = 2'b00; stg_ready = 2'b11; id_valid = 1'b0;
    mc_issue = 1'b1; mc_rd = 5'd0;
    step();
    mc_issue = 1'b0;
    check("x0_busy", busy_vec, 32'h0);

    // Reset asserted mid-operation drops busy state and the counter immediately.
    mc_issue = 1'b1; mc_rd = 5'd5;
    step();
    mc_issue = 1'b0;
    check("mid_busy_set", busy_vec, 32'h0000_0020);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_vec, 32'h0);
    check("mid_rst_cnt", stall_cnt, 16'h0);
    #1 rst_n = 1'b1;

    // Counter saturation under a permanent load-use stall.
    stg_rd = {5'd0, 5'd9}; stg_regwrite = 2'b01; stg_ready = 2'b10; id_rs2 = 5'd9; id_valid = 1'b1;
    repeat (65534) step();
    check("sat_fffe", stall_cnt, 16'hFFFE);
    step();
    check("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (6) step();
    check("sat_hold", stall_cnt, 16'hFFFF);
    check("sat_stall", stall, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit.
- Selects bypass sources for the two source operands across NUM_FWD in-order pipeline stages plus one multi-cycle-unit writeback port.
- Detects load-use style hazards, where the matching stage's result is not yet ready, and raises a stall.
- Tracks registers with outstanding multi-cycle results (MUL/DIV) in a busy scoreboard and stalls readers until writeback. Sits beside the ID/EX boundary.

Parameters:
- NUM_REGS, 32, architectural register count (x0 hard-wired zero)
- REG_AW, 5, register address width, clog2(NUM_REGS)
- NUM_FWD, 2, in-order bypass stages; index 0 is the youngest (EX/MEM), 1 is MEM/WB
- SEL_W, clog2(NUM_FWD+2), forward-select width
- CNT_W, 16, stall performance-counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  REG_AW  sources of the instruction entering EX
- id_valid  in  1  instruction in ID/EX is valid
- stg_rd  in  NUM_FWD*REG_AW  destination per stage, packed, index 0 in LSBs
- stg_regwrite  in  NUM_FWD  stage writes a register
- stg_ready  in  NUM_FWD  stage result is available on its bypass (0 for a load in EX/MEM)
- mc_issue  in  1  multi-cycle op issued this cycle (qualified by !stall externally)
- mc_rd  in  REG_AW  destination of the issued multi-cycle op
- mc_wb_valid  in  1  multi-cycle unit presents its result this cycle
- mc_wb_rd  in  REG_AW  destination of that result
- mc_kill  in  1  multi-cycle unit aborted; all outstanding ops discarded
- fwd_a, fwd_b  out  SEL_W  source select: 0 = regfile, k (1..NUM_FWD) = stage k-1, NUM_FWD+1 = MC writeback
- stall  out  1  hold ID/IF and insert a bubble into EX
- busy_vec  out  NUM_REGS  scoreboard state (debug)
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0): busy_vec=0 and stall_cnt=0. fwd_a, fwd_b and stall are combinational; with idle inputs they read 0.
- Operand match: a source matches stage k if stg_regwrite[k], stg_rd[k]==rs and rs!=0.
- Forward priority: youngest matching stage wins (lowest k). If no stage matches and mc_wb_valid && mc_wb_rd==rs && rs!=0, select NUM_FWD+1. Otherwise select 0.
- x0: never forwarded, never stalls, never set busy.
- Data hazard: stall_data=1 if the winning stage for rs1 or rs2 has stg_ready=0. A younger not-ready match stalls even if an older stage is ready.
- Scoreboard hazard: stall_sb=1 if busy_vec[rs]=1 for rs1 or rs2 and that register is not being written back this cycle (mc_wb_valid && mc_wb_rd==rs releases it in the same cycle).
- WAW: mc_issue-eligible instruction whose mc_rd is busy also stalls. Only evaluated when id_valid.
- Output: stall = id_valid && (stall_data || stall_sb || waw). fwd_a and fwd_b are valid regardless of id_valid.
- Scoreboard update (posedge):
  - Clear busy[mc_wb_rd] on mc_wb_valid.
  - Then set busy[mc_rd] on mc_issue && mc_rd!=0.
  - Issue and writeback to the same rd in the same cycle leave busy=1 (the new op is outstanding).
- mc_kill: all busy bits clear next edge and override same-cycle issue and writeback.
- Writeback to a non-busy register: no state change, no error.
- stall_cnt: +1 per cycle with stall=1; saturates at all-ones and does not wrap.
- Latency: all hazard/forward outputs are zero-cycle combinational. Scoreboard changes are visible the cycle after the edge.
- Reset asserted mid-operation: busy state is lost immediately. The MC unit is reset by the same rst_n.

Decomposition:
- Shared package fwd_pkg holds:
  - fwd_sel_e encoding constants FWD_RF=0 and FWD_MC=NUM_FWD+1
  - a reg_addr_t typedef
- One sub-module, fwd_operand_sel, performs the per-operand priority match and returns {sel, not_ready}. It is instantiated twice (rs1, rs2).
- The scoreboard, WAW check and counter stay in the top module.

Test Plan:
- Reset with stg_regwrite=2'b11, all rd=3, id_rs1=3, rs2=0, stg_ready=2'b11, rst_n released -> fwd_a=1, fwd_b=0, stall=0, busy_vec=0, stall_cnt=0.
- Priority: stage0 rd=7 and stage1 rd=7, both regwrite and ready, rs1=rs2=7 -> fwd_a=fwd_b=1; drop stage0 regwrite -> both 2.
- Load-use: stage0 rd=9, stg_ready[0]=0, rs2=9, id_valid=1 -> stall=1 and stall_cnt increments; next cycle stg_ready[0]=1 -> stall=0, fwd_b=1.
- MC hazard: mc_issue rd=5 -> busy_vec[5]=1. rs1=5 stalls 3 cycles. mc_wb_valid rd=5 -> same-cycle stall=0, fwd_a=3 (NUM_FWD+1); next cycle busy_vec[5]=0.
- Simultaneous: busy[12]=1, mc_wb_valid rd=12 with mc_issue rd=12 -> busy[12] stays 1. mc_kill with mc_issue rd=4 -> busy_vec=0.
- Boundaries:
  - rs1=0 with stage0 rd=0 regwrite -> fwd_a=0, stall=0.
  - mc_issue rd=0 -> busy_vec unchanged.
  - Force stall for 2^CNT_W+5 cycles -> stall_cnt=all-ones.
